rv32i_dbg_apb: RTL and testbench

- APB3 debug responder that is the initiator side of the register file's debug port.
- Halts and resumes the RV32I core, single-steps it, and reads/writes GPRs x0–x31 and the PC on behalf of an external debugger.
- Sits between the system APB3 bus and the core's halt/step/debug-access inputs.

---
 rtl/rv32i_dbg_pkg.sv | 33 +++
 rtl/rv32i_dbg_apb_if.sv | 23 ++
 rtl/rv32i_dbg_halt_ctrl.sv | 70 +++++++
 rtl/rv32i_dbg_apb.sv | 155 +++++++++++++++
 tb/tb_rv32i_dbg_apb.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_dbg_pkg.sv
// Shared definitions for the RV32I APB debug responder: register map,
// CTRL/STATUS bit positions and the state encodings of both FSMs.
package rv32i_dbg_pkg;

   localparam logic [8:0] OFF_CTRL     = 9'h000;
   localparam logic [8:0] OFF_STATUS   = 9'h004;
   localparam logic [8:0] OFF_PC       = 9'h008;
   localparam logic [8:0] OFF_GPR_BASE = 9'h100;

   localparam int CTRL_HALT   = 0;
   localparam int CTRL_RESUME = 1;
   localparam int CTRL_STEP   = 2;

   localparam int ST_HALTED    = 0;
   localparam int ST_HALT_PEND = 1;
   localparam int ST_RUN_PEND  = 2;
   localparam int ST_TIMEOUT   = 3;
   localparam int ST_ACC_ERR   = 4;

   typedef enum logic [1:0] {APB_IDLE, APB_WAIT, APB_DONE} apb_state_e;

   typedef enum logic [2:0] {
      H_RUN, H_HALT_REQ, H_HALTED, H_RESUME_REQ, H_STEP_REQ, H_STEP_WAIT
   } halt_state_e;

   typedef enum logic [2:0] {R_CTRL, R_STATUS, R_PC, R_GPR, R_BAD} reg_sel_e;

   // GPR window 0x100-0x17C, word aligned only
   function automatic logic is_gpr_off(input logic [8:0] off);
      return (off[8:7] == OFF_GPR_BASE[8:7]) && (off[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/rv32i_dbg_apb_if.sv
// APB3 bus bundle between the system bus and the debug responder.
interface rv32i_dbg_apb_if #(parameter int ADDR_W = 12);

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [31:0]       pwdata;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/rv32i_dbg_halt_ctrl.sv
// Core halt/resume/step sequencer with a bounded wait for core_halted.
// Request lines are registered copies of the state, so they lag it by one cycle.
module rv32i_dbg_halt_ctrl
   import rv32i_dbg_pkg::*;
#(
   parameter int HALT_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt_p,
   input  logic        resume_p,
   input  logic        step_p,
   input  logic        core_halted,
   output logic        halt_req,
   output logic        resume_req,
   output logic        step,
   output halt_state_e state,
   output logic        timeout_p
);

   localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;
   logic             cnt_hit;

   assign cnt_hit = (cnt == CNT_W'(HALT_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= H_RUN;
         cnt        <= '0;
         halt_req   <= 1'b0;
         resume_req <= 1'b0;
         step       <= 1'b0;
         timeout_p  <= 1'b0;
      end else begin
         halt_req   <= (state == H_HALT_REQ);
         resume_req <= (state == H_RESUME_REQ) || (state == H_STEP_REQ);
         step       <= (state == H_STEP_REQ) || (state == H_STEP_WAIT);
         timeout_p  <= 1'b0;
         cnt        <= '0;
         case (state)
            H_RUN:
               if (halt_p) state <= H_HALT_REQ;
            H_HALT_REQ:
               if (core_halted) state <= H_HALTED;
               else if (cnt_hit) begin
                  state     <= H_RUN;
                  timeout_p <= 1'b1;
               end else cnt <= cnt + 1'b1;
            H_HALTED:
               if (step_p)        state <= H_STEP_REQ;
               else if (resume_p) state <= H_RESUME_REQ;
            H_RESUME_REQ:
               if (!core_halted) state <= H_RUN;
            H_STEP_REQ:
               if (!core_halted) state <= H_STEP_WAIT;
            H_STEP_WAIT:
               if (core_halted) state <= H_HALTED;
               else if (cnt_hit) begin
                  state     <= H_RUN;
                  timeout_p <= 1'b1;
               end else cnt <= cnt + 1'b1;
            default:
               state <= H_RUN;
         endcase
      end
   end

endmodule

// File: rtl/rv32i_dbg_apb.sv
// APB3 debug responder: decodes the debug register map, guards GPR/PC access
// on the core being halted, and drives the register file debug port.
module rv32i_dbg_apb
   import rv32i_dbg_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int HALT_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rv32i_dbg_apb_if.slave        apb,
   output logic                  dbg_halt_req,
   output logic                  dbg_resume_req,
   output logic                  dbg_step,
   input  logic                  core_halted,
   output logic                  dbg_wr_en,
   output logic [4:0]            dbg_wr_addr,
   output logic [31:0]           dbg_wr_data,
   output logic [4:0]            dbg_rd_addr,
   input  logic [31:0]           dbg_rd_data,
   input  logic [31:0]           dbg_pc_rdata,
   output logic                  dbg_pc_wr_en,
   output logic [31:0]           dbg_pc_wdata
);

   apb_state_e        apb_st;
   halt_state_e       hstate;
   reg_sel_e          sel;
   logic [ADDR_W-1:0] paddr_w;
   logic [8:0]        off;
   logic              unused_paddr;
   logic              halted;
   logic              err;
   logic              halt_p, resume_p, step_p;
   logic              timeout_p;
   logic              timeout_f, acc_err_f;
   logic [31:0]       status;

   assign paddr_w      = apb.paddr;
   assign off          = paddr_w[8:0];
   assign unused_paddr = ^paddr_w[ADDR_W-1:9];
   assign dbg_rd_addr  = off[6:2];
   assign halted       = (hstate == H_HALTED);

   always_comb begin
      sel = R_BAD;
      if (off == OFF_CTRL)        sel = R_CTRL;
      else if (off == OFF_STATUS) sel = R_STATUS;
      else if (off == OFF_PC)     sel = R_PC;
      else if (is_gpr_off(off))   sel = R_GPR;
   end

   // GPR/PC are only reachable through the regfile port while the core is parked
   assign err = (sel == R_BAD) || (((sel == R_PC) || (sel == R_GPR)) && !halted);

   always_comb begin
      status                = '0;
      status[ST_HALTED]     = halted;
      status[ST_HALT_PEND]  = (hstate == H_HALT_REQ);
      status[ST_RUN_PEND]   = (hstate == H_RESUME_REQ) || (hstate == H_STEP_REQ) ||
                              (hstate == H_STEP_WAIT);
      status[ST_TIMEOUT]    = timeout_f;
      status[ST_ACC_ERR]    = acc_err_f;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apb_st       <= APB_IDLE;
         apb.prdata   <= '0;
         apb.pready   <= 1'b0;
         apb.pslverr  <= 1'b0;
         dbg_wr_en    <= 1'b0;
         dbg_wr_addr  <= '0;
         dbg_wr_data  <= '0;
         dbg_pc_wr_en <= 1'b0;
         dbg_pc_wdata <= '0;
         halt_p       <= 1'b0;
         resume_p     <= 1'b0;
         step_p       <= 1'b0;
         timeout_f    <= 1'b0;
         acc_err_f    <= 1'b0;
      end else begin
         apb.pready   <= 1'b0;
         apb.pslverr  <= 1'b0;
         dbg_wr_en    <= 1'b0;
         dbg_pc_wr_en <= 1'b0;
         halt_p       <= 1'b0;
         resume_p     <= 1'b0;
         step_p       <= 1'b0;
         case (apb_st)
            APB_IDLE:
               if (apb.psel && apb.penable) apb_st <= APB_WAIT;
            APB_WAIT: begin
               apb_st      <= APB_DONE;
               apb.pready  <= 1'b1;
               apb.pslverr <= err;
               if (err) begin
                  acc_err_f <= 1'b1;
                  if (!apb.pwrite) apb.prdata <= '0;
               end else if (apb.pwrite) begin
                  case (sel)
                     R_CTRL: begin
                        halt_p   <= apb.pwdata[CTRL_HALT];
                        resume_p <= apb.pwdata[CTRL_RESUME];
                        step_p   <= apb.pwdata[CTRL_STEP];
                     end
                     R_STATUS: begin
                        if (apb.pwdata[ST_TIMEOUT]) timeout_f <= 1'b0;
                        if (apb.pwdata[ST_ACC_ERR]) acc_err_f <= 1'b0;
                     end
                     R_PC: begin
                        dbg_pc_wr_en <= 1'b1;
                        dbg_pc_wdata <= apb.pwdata;
                     end
                     R_GPR: begin
                        dbg_wr_en   <= 1'b1;
                        dbg_wr_addr <= off[6:2];
                        dbg_wr_data <= apb.pwdata;
                     end
                     default: ;
                  endcase
               end else begin
                  case (sel)
                     R_STATUS: apb.prdata <= status;
                     R_PC:     apb.prdata <= dbg_pc_rdata;
                     R_GPR:    apb.prdata <= dbg_rd_data;
                     default:  apb.prdata <= '0;
                  endcase
               end
            end
            APB_DONE:
               apb_st <= APB_IDLE;
            default:
               apb_st <= APB_IDLE;
         endcase
         // a fresh timeout wins over a simultaneous W1C
         if (timeout_p) timeout_f <= 1'b1;
      end
   end

   rv32i_dbg_halt_ctrl #(.HALT_TIMEOUT(HALT_TIMEOUT)) u_halt (
      .clk         (clk),
      .rst_n       (rst_n),
      .halt_p      (halt_p),
      .resume_p    (resume_p),
      .step_p      (step_p),
      .core_halted (core_halted),
      .halt_req    (dbg_halt_req),
      .resume_req  (dbg_resume_req),
      .step        (dbg_step),
      .state       (hstate),
      .timeout_p   (timeout_p)
   );

endmodule

// File: tb/tb_rv32i_dbg_apb.sv
// Directed + randomized bench for rv32i_dbg_apb; the bench plays regfile, PC and core.
module tb_rv32i_dbg_apb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_halted = 1'b0;
   logic        dbg_halt_req, dbg_resume_req, dbg_step;
   logic        dbg_wr_en, dbg_pc_wr_en;
   logic [4:0]  dbg_wr_addr, dbg_rd_addr;
   logic [31:0] dbg_wr_data, dbg_rd_data, dbg_pc_rdata, dbg_pc_wdata;

   int tests = 0;
   int fails = 0;

   logic [31:0] rf [32] = '{default: 32'h0};
   logic [31:0] pc_reg = 32'h0000_1000;
   int          wr_cnt = 0;
   int          pc_cnt = 0;
   int          bad_resume = 0;

   rv32i_dbg_apb_if #(.ADDR_W(12)) apb_if ();

   rv32i_dbg_apb #(.ADDR_W(12), .HALT_TIMEOUT(1024)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .apb            (apb_if.slave),
      .dbg_halt_req   (dbg_halt_req),
      .dbg_resume_req (dbg_resume_req),
      .dbg_step       (dbg_step),
      .core_halted    (core_halted),
      .dbg_wr_en      (dbg_wr_en),
      .dbg_wr_addr    (dbg_wr_addr),
      .dbg_wr_data    (dbg_wr_data),
      .dbg_rd_addr    (dbg_rd_addr),
      .dbg_rd_data    (dbg_rd_data),
      .dbg_pc_rdata   (dbg_pc_rdata),
      .dbg_pc_wr_en   (dbg_pc_wr_en),
      .dbg_pc_wdata   (dbg_pc_wdata)
   );

   always #5 clk = ~clk;

   assign dbg_rd_data  = rf[dbg_rd_addr];
   assign dbg_pc_rdata = pc_reg;

   // regfile / PC behaviour seen by the debug port
   always @(posedge clk) begin
      if (dbg_wr_en) begin
         wr_cnt <= wr_cnt + 1;
         if (dbg_wr_addr != 5'd0) rf[dbg_wr_addr] <= dbg_wr_data;
      end
      if (dbg_pc_wr_en) begin
         pc_cnt <= pc_cnt + 1;
         pc_reg <= dbg_pc_wdata;
      end
      if (dbg_resume_req && !dbg_step) bad_resume <= bad_resume + 1;
   end

   // reference model state
   logic [31:0] m_rf [32] = '{default: 32'h0};
   logic [31:0] m_pc = 32'h0000_1000;
   logic        m_halted = 1'b0;
   logic        m_to = 1'b0;
   logic        m_err = 1'b0;

   function automatic logic [31:0] m_status();
      return {27'd0, m_err, m_to, 2'b00, m_halted};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output logic we,
                      output logic [4:0] wa, output logic [31:0] wdo, output logic pwe,
                      output int dw, output int dp);
      int w0, p0, lat;
      w0 = wr_cnt;
      p0 = pc_cnt;
      @(negedge clk);
      apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = wr;
      apb_if.paddr = addr; apb_if.pwdata = wd;
      @(negedge clk);
      apb_if.penable = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!apb_if.pready && lat < 20);
      chk("apb_latency", 32'(lat), 32'd2);
      rd  = apb_if.prdata;
      err = apb_if.pslverr;
      we  = dbg_wr_en;
      wa  = dbg_wr_addr;
      wdo = dbg_wr_data;
      pwe = dbg_pc_wr_en;
      @(negedge clk);
      apb_if.psel = 1'b0; apb_if.penable = 1'b0;
      @(posedge clk); #1;
      dw = wr_cnt - w0;
      dp = pc_cnt - p0;
   endtask

   logic [31:0] rd, wdo;
   logic        err, we, pwe;
   logic [4:0]  wa;
   int          dw, dp;

   task automatic wr_reg(input logic [11:0] a, input logic [31:0] d);
      apb(1'b1, a, d, rd, err, we, wa, wdo, pwe, dw, dp);
   endtask

   task automatic rd_reg(input logic [11:0] a);
      apb(1'b0, a, 32'h0, rd, err, we, wa, wdo, pwe, dw, dp);
   endtask

   logic [8:0] bad_offs [6] = '{9'h00C, 9'h010, 9'h0FC, 9'h180, 9'h1FC, 9'h102};

   initial begin
      logic [8:0]  off;
      logic [11:0] a;
      logic [31:0] d;
      logic [4:0]  idx;
      logic [2:0]  hi;
      int kind, hcnt, n, br0, w0;

      apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
      apb_if.paddr = '0; apb_if.pwdata = '0;
      #23 rst_n = 1'b1;
      idle(1);

      chk("rst_ctl", 32'({dbg_halt_req, dbg_resume_req, dbg_step, dbg_wr_en, dbg_pc_wr_en,
                          apb_if.pready, apb_if.pslverr}), 32'd0);
      chk("rst_prdata", apb_if.prdata, 32'd0);
      chk("rst_wr_data", dbg_wr_data | dbg_pc_wdata | 32'(dbg_wr_addr), 32'd0);
      rd_reg(12'h004);
      chk("status_reset", rd, m_status());

      // CTRL.RESUME while running is ignored
      wr_reg(12'h000, 32'h2);
      chk("resume_in_run_err", 32'(err), 32'd0);
      rd_reg(12'h004);
      chk("resume_in_run_status", rd, m_status());

      // halt handshake
      wr_reg(12'h000, 32'h1);
      chk("halt_wr_err", 32'(err), 32'd0);
      idle(3);
      chk("halt_req_high", 32'(dbg_halt_req), 32'd1);
      @(negedge clk) core_halted = 1'b1;
      idle(3);
      chk("halt_req_drop", 32'(dbg_halt_req), 32'd0);
      m_halted = 1'b1;
      rd_reg(12'h004);
      chk("status_halted", rd, m_status());

      // GPR write + readback
      wr_reg(12'h114, 32'hDEADBEEF);
      chk("gpr_wr_err", 32'(err), 32'd0);
      chk("gpr_wr_en", 32'(we), 32'd1);
      chk("gpr_wr_addr", 32'(wa), 32'd5);
      chk("gpr_wr_data", wdo, 32'hDEADBEEF);
      chk("gpr_wr_pulses", 32'(dw), 32'd1);
      m_rf[5] = 32'hDEADBEEF;
      rd_reg(12'h114);
      chk("gpr_rd", rd, m_rf[5]);

      // randomized traffic while halted
      for (int i = 0; i < 48; i++) begin
         kind = $urandom_range(0, 5);
         idx  = 5'($urandom_range(0, 31));
         d    = $urandom;
         hi   = 3'($urandom_range(0, 7));
         off  = 9'h100 + {2'b00, idx, 2'b00};
         case (kind)
            0: begin
               wr_reg({hi, off}, d);
               chk("rnd_gpr_wr_err", 32'(err), 32'd0);
               chk("rnd_gpr_wr_strobe", {26'd0, we, wa}, {26'd0, 1'b1, idx});
               chk("rnd_gpr_wr_data", wdo, d);
               if (idx != 5'd0) m_rf[idx] = d;
            end
            1: begin
               rd_reg({hi, off});
               chk("rnd_gpr_rd_err", 32'(err), 32'd0);
               chk("rnd_gpr_rd", rd, m_rf[idx]);
            end
            2: begin
               wr_reg({hi, 9'h008}, d);
               chk("rnd_pc_wr", {31'd0, pwe}, 32'd1);
               m_pc = d;
            end
            3: begin
               rd_reg({hi, 9'h008});
               chk("rnd_pc_rd", rd, m_pc);
            end
            4: begin
               a = {hi, bad_offs[$urandom_range(0, 5)]};
               if ($urandom_range(0, 1) == 1) begin
                  wr_reg(a, d);
                  chk("rnd_bad_wr_strobes", 32'(dw + dp), 32'd0);
               end else begin
                  rd_reg(a);
                  chk("rnd_bad_rd_data", rd, 32'd0);
               end
               chk("rnd_bad_err", 32'(err), 32'd1);
               m_err = 1'b1;
            end
            default: begin
               rd_reg({hi, 9'h004});
               chk("rnd_status", rd, m_status());
            end
         endcase
      end
      wr_reg(12'h004, 32'h10);
      m_err = 1'b0;
      rd_reg(12'h004);
      chk("status_w1c_err", rd, m_status());

      // step wins over resume
      br0 = bad_resume;
      wr_reg(12'h000, 32'h6);
      idle(3);
      chk("step_req", {30'd0, dbg_step, dbg_resume_req}, 32'h3);
      @(negedge clk) core_halted = 1'b0;
      idle(3);
      chk("step_wait", {30'd0, dbg_step, dbg_resume_req}, 32'h2);
      rd_reg(12'h004);
      chk("step_pending", rd, 32'h4);
      @(negedge clk) core_halted = 1'b1;
      idle(3);
      chk("step_done", {30'd0, dbg_step, dbg_resume_req}, 32'h0);
      chk("resume_without_step", 32'(bad_resume - br0), 32'd0);
      rd_reg(12'h004);
      chk("status_after_step", rd, m_status());

      // resume
      wr_reg(12'h000, 32'h2);
      idle(3);
      chk("resume_req", 32'(dbg_resume_req), 32'd1);
      @(negedge clk) core_halted = 1'b0;
      idle(3);
      chk("resume_drop", 32'(dbg_resume_req), 32'd0);
      m_halted = 1'b0;

      // access guard while running
      wr_reg(12'h104, 32'h55AA55AA);
      chk("guard_wr_err", 32'(err), 32'd1);
      chk("guard_wr_strobes", 32'(dw), 32'd0);
      m_err = 1'b1;
      rd_reg(12'h008);
      chk("guard_pc_rd", {rd[30:0], err}, 32'd1);
      rd_reg(12'h004);
      chk("status_acc_err", rd, m_status());
      wr_reg(12'h004, 32'h10);
      m_err = 1'b0;
      rd_reg(12'h004);
      chk("status_acc_err_clr", rd, m_status());

      // halt timeout
      wr_reg(12'h000, 32'h1);
      hcnt = 0;
      n = 0;
      while (n < 3000) begin
         @(posedge clk); #1; n++;
         if (dbg_halt_req) hcnt++;
         else if (hcnt > 0) break;
      end
      chk("timeout_len", 32'(hcnt), 32'd1024);
      m_to = 1'b1;
      rd_reg(12'h004);
      chk("status_timeout", rd, m_status());
      wr_reg(12'h004, 32'h8);
      m_to = 1'b0;
      rd_reg(12'h004);
      chk("status_timeout_clr", rd, m_status());

      // halt again, PC write/read, bad offset
      wr_reg(12'h000, 32'h1);
      idle(2);
      @(negedge clk) core_halted = 1'b1;
      idle(3);
      m_halted = 1'b1;
      wr_reg(12'h008, 32'h80000000);
      chk("pc_wr_pulse", {pwe, 31'(dp)}, {1'b1, 31'd1});
      chk("pc_wr_data", pc_reg, 32'h80000000);
      m_pc = 32'h80000000;
      rd_reg(12'h008);
      chk("pc_rd", rd, m_pc);
      rd_reg(12'h00C);
      chk("bad_00c", {rd[30:0], err}, 32'd1);

      // reset during the wait state abandons the transfer
      w0 = wr_cnt;
      @(negedge clk);
      apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
      apb_if.paddr = 12'h108; apb_if.pwdata = 32'h12345678;
      @(negedge clk) apb_if.penable = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wait_ctl", 32'({dbg_halt_req, dbg_resume_req, dbg_step, dbg_wr_en, dbg_pc_wr_en,
                               apb_if.pready, apb_if.pslverr}), 32'd0);
      chk("rst_wait_prdata", apb_if.prdata, 32'd0);
      apb_if.psel = 1'b0; apb_if.penable = 1'b0;
      idle(3);
      @(negedge clk) rst_n = 1'b1;
      idle(2);
      chk("rst_wait_no_strobe", 32'(wr_cnt - w0), 32'd0);
      m_halted = 1'b0;
      m_err = 1'b0;
      m_to = 1'b0;
      rd_reg(12'h004);
      chk("status_after_rst", rd, m_status());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
